hazard_scoreboard_ctrl: RTL and testbench
=========================================

Name: hazard_scoreboard_ctrl

Overview:
- Parametrised successor to the pipeline's combinational hazard unit.
- Stages decode their own instructions into generic (address, write-enable, Tnew/Tuse) tuples, so the block has no per-opcode tables.
- Generates the D-stage stall, flush and enables, plus forwarding selects for D, E and M.
- Adds a sequential multiply/divide busy tracker and a saturating stall-cycle performance counter.
- Sits beside the five-stage datapath (F/D/E/M/W).

Parameters:
- REG_AW, 5, register-address width; address 0 is hard-wired zero and never creates a hazard or forward.
- T_W, 2, width of the Tnew/Tuse fields.
- MULT_CYC, 5, busy cycles after a multiply start, range 1..2^MD_CW-1.
- DIV_CYC, 10, busy cycles after a divide start, range 1..2^MD_CW-1.
- MD_CW, 4, MDU busy-counter width.
- PERF_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_d, rt_d  in  REG_AW  D-stage source addresses.
- use_rs_d, use_rt_d  in  1  D instruction reads rs / rt.
- tuse_rs_d, tuse_rt_d  in  T_W  cycles from D until the operand is consumed (0 = consumed in D, e.g. branch or jr).
- rs_e, rt_e  in  REG_AW  E-stage source addresses.
- use_rs_e, use_rt_e  in  1  E instruction consumes rs / rt in E.
- rt_m  in  REG_AW  M-stage store-data source.
- use_rt_m  in  1  M instruction is a store needing rt.
- wa_e, wa_m, wa_w  in  REG_AW  destination address per stage.
- we_e, we_m, we_w  in  1  stage instruction writes the register file.
- tnew_e, tnew_m  in  T_W  cycles until the stage's result exists. W is always 0.
- md_use_d  in  1  D instruction touches the MDU (mult, div, mfhi, mflo, mthi, mtlo).
- md_start_e  in  1  single-cycle pulse: E instruction starts the MDU.
- md_div_e  in  1  qualifies md_start_e: 1 = divide, 0 = multiply.
- stall  out  1  freeze PC and F/D, bubble D/E.
- pc_en, d_en  out  1  equal to ~stall.
- e_flush  out  1  equal to stall.
- fwd_rs_d, fwd_rt_d  out  2  D-stage operand select: 0 = RF, 1 = E, 2 = M, 3 = W.
- fwd_rs_e, fwd_rt_e  out  2  E-stage operand select: 0 = pipe reg, 1 = M, 2 = W.
- fwd_rt_m  out  1  M-stage store-data select: 1 = W result.
- md_busy  out  1  MDU occupied.
- stall_cnt  out  PERF_W  total stall cycles since reset.

Behaviour:
- match(x, s) = we_x & (wa_x == s) & (s != 0).
- Data stall for each D source s with use_s set: (match(E, s) & tnew_e > tuse_s) | (match(M, s) & tnew_m > tuse_s).
- MDU stall: md_use_d & md_busy.
- stall = data stall | MDU stall. It is combinational, same cycle.
- D forward selects:
  - Priority E > M > W.
  - E is eligible only if match(E) and tnew_e == 0; M only if match(M) and tnew_m == 0; W on match(W).
  - A match whose Tnew is non-zero blocks lower-priority stages for that operand and yields select 0. The stall covers correctness in that case.
  - Output is 0 when use_s = 0.
- E forward selects: priority M (match and tnew_m == 0) > W.
- fwd_rt_m = use_rt_m & match(W, rt_m).
- MDU counter md_cnt, MD_CW bits:
  - On md_start_e it loads DIV_CYC or MULT_CYC; otherwise it decrements when non-zero and holds at 0.
  - A start while md_cnt != 0 reloads (restart). This is legal and not an error.
  - md_busy = md_start_e | (md_cnt != 0). A start is therefore visible in the same cycle, and busy drops in the cycle md_cnt reaches 0.
  - Example: a multiply started at cycle t has md_busy high for cycles t .. t+MULT_CYC.
- stall_cnt:
  - Increments on each rising edge where stall = 1.
  - Saturates at all-ones and does not wrap.
- Reset (rst_n low, asynchronous): md_cnt = 0 and stall_cnt = 0, so md_busy = 0. All other outputs follow their combinational inputs.
  - Reset mid-divide aborts the busy window immediately.
- Simultaneous events:
  - md_start_e with md_use_d in the same cycle: stall asserted.
  - Data and MDU stall together: a single stall, counted once.
- Register 0 is never matched, for any stage, source or forward.

Test Plan:
- Load-use: wa_e = 8, we_e = 1, tnew_e = 2; D is add with rs_d = 8, tuse = 1 -> stall = 1, pc_en = 0, e_flush = 1. Next cycle, with the load in M and tnew_m = 1 -> stall = 0, fwd_rs_d = 0. Cycle after, with it in W -> fwd_rs_d = 3.
- Branch after ALU op: wa_e = 5, tnew_e = 1, tuse_rs_d = 0 -> stall = 1. Next cycle, M with tnew_m = 0 -> stall = 0, fwd_rs_d = 2.
- Priority: E, M and W all write r9 with tnew 0; D reads rt = 9 -> fwd_rt_d = 1. With E removed -> 2. Destination r0 on every stage -> 0.
- MDU: md_start_e with md_div_e = 1 at cycle 0 and DIV_CYC = 10 -> md_busy high for cycles 0..10, low at 11. md_use_d at cycle 5 -> stall = 1. md_use_d at cycle 11 -> stall = 0.
- Reset mid-divide: assert rst_n low at cycle 4 asynchronously -> md_busy = 0 and stall_cnt = 0 before the next edge.
- Counter saturation with PERF_W = 4: hold stall for 20 cycles -> stall_cnt = 15 and it stays at 15.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Hazard scoreboard interface: stage decode tuples in, stall/forward controls out.
interface hazard_scoreboard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2,
    parameter int PERF_W = 16
);
    logic [REG_AW-1:0] rs_d, rt_d;
    logic              use_rs_d, use_rt_d;
    logic [T_W-1:0]    tuse_rs_d, tuse_rt_d;
    logic [REG_AW-1:0] rs_e, rt_e;
    logic              use_rs_e, use_rt_e;
    logic [REG_AW-1:0] rt_m;
    logic              use_rt_m;
    logic [REG_AW-1:0] wa_e, wa_m, wa_w;
    logic              we_e, we_m, we_w;
    logic [T_W-1:0]    tnew_e, tnew_m;
    logic              md_use_d, md_start_e, md_div_e;

    logic              stall, pc_en, d_en, e_flush;
    logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic              fwd_rt_m;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cnt;

    // The datapath side drives the decode tuples and consumes the controls.
    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
               rs_e, rt_e, use_rs_e, use_rt_e, rt_m, use_rt_m,
               wa_e, wa_m, wa_w, we_e, we_m, we_w, tnew_e, tnew_m,
               md_use_d, md_start_e, md_div_e,
        input  stall, pc_en, d_en, e_flush, fwd_rs_d, fwd_rt_d,
               fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy, stall_cnt
    );

    // The hazard unit side.
    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
               rs_e, rt_e, use_rs_e, use_rt_e, rt_m, use_rt_m,
               wa_e, wa_m, wa_w, we_e, we_m, we_w, tnew_e, tnew_m,
               md_use_d, md_start_e, md_div_e,
        output stall, pc_en, d_en, e_flush, fwd_rs_d, fwd_rt_d,
               fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Generic Tnew/Tuse hazard unit for a five-stage pipeline, with an MDU busy
// tracker and a saturating stall-cycle counter.
module hazard_scoreboard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int T_W      = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int MD_CW    = 4,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_ctrl_if.slave hz
);
    typedef logic [REG_AW-1:0] addr_t;
    typedef logic [T_W-1:0]    t_t;

    localparam logic [MD_CW-1:0] MULT_LD = MD_CW'(MULT_CYC);
    localparam logic [MD_CW-1:0] DIV_LD  = MD_CW'(DIV_CYC);

    logic [MD_CW-1:0]  md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              stall_c, md_busy_c;
    logic              data_stall, md_stall;
    logic [1:0]        fwd_rs_d_c, fwd_rt_d_c, fwd_rs_e_c, fwd_rt_e_c;
    logic              fwd_rt_m_c;

    // Register 0 is hard-wired zero and must never look like a producer.
    function automatic logic match(input logic we, input addr_t wa, input addr_t s);
        return we && (wa == s) && (s != '0);
    endfunction

    // A source stalls D when a producer in E or M will not have its result
    // ready by the time the D instruction needs it.
    function automatic logic src_stall(input logic use_s, input addr_t s, input t_t tuse,
                                       input logic we_e, input addr_t wa_e, input t_t tnew_e,
                                       input logic we_m, input addr_t wa_m, input t_t tnew_m);
        return use_s && ((match(we_e, wa_e, s) && (tnew_e > tuse)) ||
                         (match(we_m, wa_m, s) && (tnew_m > tuse)));
    endfunction

    // D-stage select: the youngest matching producer wins; if it is not ready
    // yet it still shadows older producers, and the stall protects the read.
    function automatic logic [1:0] d_sel(input logic use_s, input addr_t s,
                                         input logic we_e, input addr_t wa_e, input t_t tnew_e,
                                         input logic we_m, input addr_t wa_m, input t_t tnew_m,
                                         input logic we_w, input addr_t wa_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (!use_s)                        sel = 2'd0;
        else if (match(we_e, wa_e, s))     sel = (tnew_e == '0) ? 2'd1 : 2'd0;
        else if (match(we_m, wa_m, s))     sel = (tnew_m == '0) ? 2'd2 : 2'd0;
        else if (match(we_w, wa_w, s))     sel = 2'd3;
        return sel;
    endfunction

    // E-stage select: a ready M result beats W.
    function automatic logic [1:0] e_sel(input logic use_s, input addr_t s,
                                         input logic we_m, input addr_t wa_m, input t_t tnew_m,
                                         input logic we_w, input addr_t wa_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_s && match(we_m, wa_m, s) && (tnew_m == '0)) sel = 2'd1;
        else if (use_s && match(we_w, wa_w, s))              sel = 2'd2;
        return sel;
    endfunction

    // Combinational stall and forward-select generation.
    always_comb begin
        md_busy_c  = hz.md_start_e || (md_cnt_q != '0);
        data_stall = src_stall(hz.use_rs_d, hz.rs_d, hz.tuse_rs_d,
                               hz.we_e, hz.wa_e, hz.tnew_e, hz.we_m, hz.wa_m, hz.tnew_m) ||
                     src_stall(hz.use_rt_d, hz.rt_d, hz.tuse_rt_d,
                               hz.we_e, hz.wa_e, hz.tnew_e, hz.we_m, hz.wa_m, hz.tnew_m);
        md_stall   = hz.md_use_d && md_busy_c;
        stall_c    = data_stall || md_stall;
        fwd_rs_d_c = d_sel(hz.use_rs_d, hz.rs_d, hz.we_e, hz.wa_e, hz.tnew_e,
                           hz.we_m, hz.wa_m, hz.tnew_m, hz.we_w, hz.wa_w);
        fwd_rt_d_c = d_sel(hz.use_rt_d, hz.rt_d, hz.we_e, hz.wa_e, hz.tnew_e,
                           hz.we_m, hz.wa_m, hz.tnew_m, hz.we_w, hz.wa_w);
        fwd_rs_e_c = e_sel(hz.use_rs_e, hz.rs_e, hz.we_m, hz.wa_m, hz.tnew_m, hz.we_w, hz.wa_w);
        fwd_rt_e_c = e_sel(hz.use_rt_e, hz.rt_e, hz.we_m, hz.wa_m, hz.tnew_m, hz.we_w, hz.wa_w);
        fwd_rt_m_c = hz.use_rt_m && match(hz.we_w, hz.wa_w, hz.rt_m);
    end

    // Next-state for the MDU busy counter (a start always reloads) and the
    // stall counter (sticks at all-ones instead of wrapping).
    always_comb begin
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (hz.md_start_e)        md_cnt_d = hz.md_div_e ? DIV_LD : MULT_LD;
        else if (md_cnt_q != '0)  md_cnt_d = md_cnt_q - 1'b1;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State registers; reset aborts any MDU busy window immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall     = stall_c;
    assign hz.pc_en     = ~stall_c;
    assign hz.d_en      = ~stall_c;
    assign hz.e_flush   = stall_c;
    assign hz.fwd_rs_d  = fwd_rs_d_c;
    assign hz.fwd_rt_d  = fwd_rt_d_c;
    assign hz.fwd_rs_e  = fwd_rs_e_c;
    assign hz.fwd_rt_e  = fwd_rt_e_c;
    assign hz.fwd_rt_m  = fwd_rt_m_c;
    assign hz.md_busy   = md_busy_c;
    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares them on the falling edge of each cycle.
module tb_hazard_scoreboard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if #(.REG_AW(5), .T_W(2), .PERF_W(16)) hif ();
    hazard_scoreboard_ctrl_if #(.REG_AW(5), .T_W(2), .PERF_W(4))  sif ();

    hazard_scoreboard_ctrl #(.PERF_W(16)) dut (.clk(clk), .rst_n(rst_n),  .hz(hif));
    hazard_scoreboard_ctrl #(.PERF_W(4))  sat (.clk(clk), .rst_n(rst4_n), .hz(sif));

    typedef struct {
        logic        stall;
        logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
        logic        fwd_rt_m;
        logic        md_busy;
        logic [15:0] cnt;
        logic        sat_stall;
        logic [3:0]  sat_cnt;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_cnt  = '0;
    string       cur_tag  = "reset";

    // Build an expectation with the saturation-instance fields idle.
    function automatic exp_t mk(input logic s, input logic [1:0] rsd, input logic [1:0] rtd,
                                input logic [1:0] rse, input logic [1:0] rte,
                                input logic rtm, input logic busy);
        exp_t e;
        e.stall = s; e.fwd_rs_d = rsd; e.fwd_rt_d = rtd; e.fwd_rs_e = rse;
        e.fwd_rt_e = rte; e.fwd_rt_m = rtm; e.md_busy = busy; e.cnt = '0;
        e.sat_stall = 1'b0; e.sat_cnt = '0; e.tag = "";
        return e;
    endfunction

    task automatic clearInputs();
        hif.rs_d = '0; hif.rt_d = '0; hif.use_rs_d = 0; hif.use_rt_d = 0;
        hif.tuse_rs_d = '0; hif.tuse_rt_d = '0;
        hif.rs_e = '0; hif.rt_e = '0; hif.use_rs_e = 0; hif.use_rt_e = 0;
        hif.rt_m = '0; hif.use_rt_m = 0;
        hif.wa_e = '0; hif.wa_m = '0; hif.wa_w = '0;
        hif.we_e = 0; hif.we_m = 0; hif.we_w = 0;
        hif.tnew_e = '0; hif.tnew_m = '0;
        hif.md_use_d = 0; hif.md_start_e = 0; hif.md_div_e = 0;
    endtask

    // Queue this cycle's expectation, then advance to just past the next edge.
    task automatic applyStimulus(input exp_t e_in);
        exp_t e;
        e = e_in;
        e.cnt = exp_cnt;
        e.tag = cur_tag;
        exp_q.push_back(e);
        if (e.stall) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string name, input logic [15:0] act,
                       input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, name, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        cmp(e.tag, "stall",     16'(hif.stall),     16'(e.stall));
        cmp(e.tag, "pc_en",     16'(hif.pc_en),     16'(!e.stall));
        cmp(e.tag, "d_en",      16'(hif.d_en),      16'(!e.stall));
        cmp(e.tag, "e_flush",   16'(hif.e_flush),   16'(e.stall));
        cmp(e.tag, "fwd_rs_d",  16'(hif.fwd_rs_d),  16'(e.fwd_rs_d));
        cmp(e.tag, "fwd_rt_d",  16'(hif.fwd_rt_d),  16'(e.fwd_rt_d));
        cmp(e.tag, "fwd_rs_e",  16'(hif.fwd_rs_e),  16'(e.fwd_rs_e));
        cmp(e.tag, "fwd_rt_e",  16'(hif.fwd_rt_e),  16'(e.fwd_rt_e));
        cmp(e.tag, "fwd_rt_m",  16'(hif.fwd_rt_m),  16'(e.fwd_rt_m));
        cmp(e.tag, "md_busy",   16'(hif.md_busy),   16'(e.md_busy));
        cmp(e.tag, "stall_cnt", hif.stall_cnt,      e.cnt);
        cmp(e.tag, "sat_stall", 16'(sif.stall),     16'(e.sat_stall));
        cmp(e.tag, "sat_cnt",   16'(sif.stall_cnt), 16'(e.sat_cnt));
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        clearInputs();
        sif.rs_d = '0; sif.rt_d = '0; sif.use_rs_d = 0; sif.use_rt_d = 0;
        sif.tuse_rs_d = '0; sif.tuse_rt_d = '0;
        sif.rs_e = '0; sif.rt_e = '0; sif.use_rs_e = 0; sif.use_rt_e = 0;
        sif.rt_m = '0; sif.use_rt_m = 0;
        sif.wa_e = '0; sif.wa_m = '0; sif.wa_w = '0;
        sif.we_e = 0; sif.we_m = 0; sif.we_w = 0;
        sif.tnew_e = '0; sif.tnew_m = '0;
        sif.md_use_d = 0; sif.md_start_e = 0; sif.md_div_e = 0;
        repeat (2) @(posedge clk);
        #1;

        cur_tag = "reset";
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Load-use: E load with tnew 2, D add reads it with tuse 1.
        cur_tag = "loaduse_e";
        clearInputs(); hif.wa_e = 8; hif.we_e = 1; hif.tnew_e = 2;
        hif.rs_d = 8; hif.use_rs_d = 1; hif.tuse_rs_d = 1;
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
        cur_tag = "loaduse_m";
        clearInputs(); hif.wa_m = 8; hif.we_m = 1; hif.tnew_m = 1;
        hif.rs_d = 8; hif.use_rs_d = 1; hif.tuse_rs_d = 1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
        cur_tag = "loaduse_w";
        clearInputs(); hif.wa_w = 8; hif.we_w = 1;
        hif.rs_d = 8; hif.use_rs_d = 1; hif.tuse_rs_d = 1;
        applyStimulus(mk(0, 3, 0, 0, 0, 0, 0));

        // Branch right after an ALU op.
        cur_tag = "branch_e";
        clearInputs(); hif.wa_e = 5; hif.we_e = 1; hif.tnew_e = 1;
        hif.rs_d = 5; hif.use_rs_d = 1; hif.tuse_rs_d = 0;
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
        cur_tag = "branch_m";
        clearInputs(); hif.wa_m = 5; hif.we_m = 1; hif.tnew_m = 0;
        hif.rs_d = 5; hif.use_rs_d = 1; hif.tuse_rs_d = 0;
        applyStimulus(mk(0, 2, 0, 0, 0, 0, 0));

        // Priority among E/M/W all writing r9, every consumer reading r9.
        cur_tag = "prio_emw";
        clearInputs();
        hif.wa_e = 9; hif.wa_m = 9; hif.wa_w = 9; hif.we_e = 1; hif.we_m = 1; hif.we_w = 1;
        hif.rt_d = 9; hif.use_rt_d = 1; hif.tuse_rt_d = 1;
        hif.rs_e = 9; hif.use_rs_e = 1; hif.rt_e = 9; hif.use_rt_e = 1;
        hif.rt_m = 9; hif.use_rt_m = 1;
        applyStimulus(mk(0, 0, 1, 1, 1, 1, 0));
        cur_tag = "prio_mw";
        hif.we_e = 0;
        applyStimulus(mk(0, 0, 2, 1, 1, 1, 0));
        cur_tag = "prio_w";
        hif.we_m = 0;
        applyStimulus(mk(0, 0, 3, 2, 2, 1, 0));
        cur_tag = "use_off";
        hif.we_e = 1; hif.we_m = 1; hif.use_rt_d = 0; hif.use_rs_e = 0;
        hif.use_rt_e = 0; hif.use_rt_m = 0;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
        cur_tag = "m_blocks_w";
        clearInputs(); hif.wa_m = 9; hif.we_m = 1; hif.tnew_m = 2; hif.wa_w = 9; hif.we_w = 1;
        hif.rt_d = 9; hif.use_rt_d = 1; hif.tuse_rt_d = 2;
        hif.rs_e = 9; hif.use_rs_e = 1;
        applyStimulus(mk(0, 0, 0, 2, 0, 0, 0));
        cur_tag = "reg0";
        clearInputs(); hif.we_e = 1; hif.we_m = 1; hif.we_w = 1; hif.tnew_e = 3; hif.tnew_m = 3;
        hif.use_rs_d = 1; hif.use_rt_d = 1; hif.use_rs_e = 1; hif.use_rt_e = 1; hif.use_rt_m = 1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));

        // Divide: busy cycles 0..10, MDU consumer at 5 stalls, at 11 does not.
        for (int c = 0; c <= 11; c++) begin
            cur_tag = $sformatf("div_c%0d", c);
            clearInputs();
            hif.md_start_e = (c == 0); hif.md_div_e = (c == 0);
            hif.md_use_d = (c == 5) || (c == 11);
            applyStimulus(mk(c == 5, 0, 0, 0, 0, 0, c <= 10));
        end

        // Multiply started with a same-cycle MDU consumer, a data+MDU stall
        // at cycle 1, and a restart at cycle 3 extending busy through 8.
        for (int c = 0; c <= 9; c++) begin
            cur_tag = $sformatf("mul_c%0d", c);
            clearInputs();
            hif.md_start_e = (c == 0) || (c == 3);
            hif.md_use_d = (c == 0) || (c == 1);
            if (c == 1) begin
                hif.wa_e = 8; hif.we_e = 1; hif.tnew_e = 2;
                hif.rs_d = 8; hif.use_rs_d = 1; hif.tuse_rs_d = 1;
            end
            applyStimulus(mk((c == 0) || (c == 1), 0, 0, 0, 0, 0, c <= 8));
        end

        // Reset in the middle of a divide clears busy and the counter at once.
        for (int c = 0; c <= 5; c++) begin
            cur_tag = $sformatf("rstdiv_c%0d", c);
            clearInputs();
            hif.md_start_e = (c == 0); hif.md_div_e = (c == 0);
            if (c == 4) begin
                rst_n = 1'b0;
                exp_cnt = '0;
            end
            applyStimulus(mk(0, 0, 0, 0, 0, 0, c < 4));
            if (c == 4) rst_n = 1'b1;
        end

        // Saturation on the 4-bit instance: a permanent load-use stall.
        sif.wa_e = 8; sif.we_e = 1; sif.tnew_e = 2;
        sif.rs_d = 8; sif.use_rs_d = 1; sif.tuse_rs_d = 1;
        rst4_n = 1'b1;
        clearInputs();
        for (int i = 0; i <= 22; i++) begin
            cur_tag = $sformatf("sat_i%0d", i);
            e = mk(0, 0, 0, 0, 0, 0, 0);
            e.sat_stall = 1'b1;
            e.sat_cnt = (i < 15) ? 4'(i) : 4'd15;
            applyStimulus(e);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
